// File: rtl/regfile_pkg.sv
// Shared register-file constants and a population-count helper for the busy scoreboard.
// Depth is capped at POP_W entries by the popcount helper.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int POP_W      = 1024;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with flush/clear/claim priority and a registered busy count.
// Latency: busy updates at the edge, busy count reflects the post-edge vector.
// Backpressure: none, every claim/clear/flush is applied in the cycle presented.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr0_en,
    input  logic [ADDR_W-1:0]      i_wr0_addr,
    input  logic                   i_wr1_en,
    input  logic [ADDR_W-1:0]      i_wr1_addr,
    input  logic                   i_claim_en,
    input  logic [ADDR_W-1:0]      i_claim_addr,
    input  logic                   i_flush,
    output logic [(1<<ADDR_W)-1:0] o_busy,
    output logic [ADDR_W:0]        o_busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CNT_W-1:0] r_busy_cnt;

    // Claim is applied last so a new producer supersedes a same-cycle writeback.
    always_comb begin
        w_busy_nxt = i_flush ? '0 : r_busy;
        if (i_wr0_en)   w_busy_nxt[i_wr0_addr]   = 1'b0;
        if (i_wr1_en)   w_busy_nxt[i_wr1_addr]   = 1'b0;
        if (i_claim_en) w_busy_nxt[i_claim_addr] = 1'b1;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= CNT_W'(popcount(POP_W'(w_busy_nxt)));
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two writes (port 1 wins), optional bypass.
// Latency: reads 0 cycles; writes visible via bypass same cycle, from the array next cycle.
// Backpressure: none, all reads/writes/claims accepted every cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic                       i_wr0_en,
    input  logic [ADDR_W-1:0]          i_wr0_addr,
    input  logic [DATA_W-1:0]          i_wr0_data,
    input  logic                       i_wr1_en,
    input  logic [ADDR_W-1:0]          i_wr1_addr,
    input  logic [DATA_W-1:0]          i_wr1_data,
    input  logic                       i_claim_en,
    input  logic [ADDR_W-1:0]          i_claim_addr,
    input  logic                       i_flush,
    output logic [ADDR_W:0]            o_busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_arr [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr0_ok;
    logic              w_wr1_ok;

    assign w_wr0_ok = i_wr0_en && !((ZERO_REG != 0) && (i_wr0_addr == '0));
    assign w_wr1_ok = i_wr1_en && !((ZERO_REG != 0) && (i_wr1_addr == '0));

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr0_en     (i_wr0_en),
        .i_wr0_addr   (i_wr0_addr),
        .i_wr1_en     (i_wr1_en),
        .i_wr1_addr   (i_wr1_addr),
        .i_claim_en   (i_claim_en),
        .i_claim_addr (i_claim_addr),
        .i_flush      (i_flush),
        .o_busy       (w_busy),
        .o_busy_cnt   (o_busy_cnt)
    );

    // Port 1 is written after port 0 so the younger instruction wins on a collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_arr[i] <= '0;
            end
        end else begin
            if (w_wr0_ok) r_arr[i_wr0_addr] <= i_wr0_data;
            if (w_wr1_ok) r_arr[i_wr1_addr] <= i_wr1_data;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_a;
        logic              w_fwd0;
        logic              w_fwd1;
        o_rd_data = '0;
        o_rd_busy = '0;
        w_a       = '0;
        w_fwd0    = 1'b0;
        w_fwd1    = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_a    = i_rd_addr[k*ADDR_W +: ADDR_W];
            w_fwd1 = (BYPASS != 0) && i_wr1_en && (i_wr1_addr == w_a);
            w_fwd0 = (BYPASS != 0) && i_wr0_en && (i_wr0_addr == w_a);
            if (w_fwd1)      o_rd_data[k*DATA_W +: DATA_W] = i_wr1_data;
            else if (w_fwd0) o_rd_data[k*DATA_W +: DATA_W] = i_wr0_data;
            else             o_rd_data[k*DATA_W +: DATA_W] = r_arr[w_a];
            o_rd_busy[k] = w_busy[w_a] & ~(w_fwd0 | w_fwd1);
            if ((ZERO_REG != 0) && (w_a == '0)) begin
                o_rd_data[k*DATA_W +: DATA_W] = '0;
                o_rd_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus queues expected values per cycle, a negedge monitor pops and compares.
// Two DUTs share stimulus: dut_a with bypass, dut_b without.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    // kinds: 0 data_a, 1 busy_a, 2 cnt_a, 3 data_b, 4 busy_b, 5 cnt_b
    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     rd_busy_a, rd_busy_b;
    logic              wr0_en, wr1_en, claim_en, flush;
    logic [AW-1:0]     wr0_addr, wr1_addr, claim_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic [AW:0]       busy_cnt_a, busy_cnt_b;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a), .o_rd_busy(rd_busy_a),
        .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
        .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
        .i_claim_en(claim_en), .i_claim_addr(claim_addr), .i_flush(flush), .o_busy_cnt(busy_cnt_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
        .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
        .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
        .i_claim_en(claim_en), .i_claim_addr(claim_addr), .i_flush(flush), .o_busy_cnt(busy_cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind, input int port);
        case (kind)
            0: return rd_data_a[port*DW +: DW];
            1: return {31'b0, rd_busy_a[port]};
            2: return {26'b0, busy_cnt_a};
            3: return rd_data_b[port*DW +: DW];
            4: return {31'b0, rd_busy_b[port]};
            default: return {26'b0, busy_cnt_b};
        endcase
    endfunction

    // Monitor: outputs are combinational/registered every cycle, so each negedge presents a result.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                act = actual(e.kind, e.port);
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic expect_v(input int kind, input int port, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    // Same expectation on both DUTs (bypass-insensitive values).
    task automatic expect_ab(input int kind, input int port, input logic [31:0] v, input string name);
        expect_v(kind, port, v, {name, "_a"});
        expect_v(kind + 3, port, v, {name, "_b"});
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; claim_en = 0; flush = 0;
        wr0_addr = '0; wr1_addr = '0; claim_addr = '0;
        wr0_data = '0; wr1_data = '0;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_addr = {AW'(p1), AW'(p0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset state across every address including 31.
        for (int a = 0; a < 32; a += 2) begin
            set_rd(a, a + 1);
            expect_ab(0, 0, 32'h0, "rst_data_p0");
            expect_ab(0, 1, 32'h0, "rst_data_p1");
            expect_ab(1, 0, 32'h0, "rst_busy_p0");
            expect_ab(1, 1, 32'h0, "rst_busy_p1");
            expect_ab(2, 0, 32'h0, "rst_cnt");
            step();
        end

        // Single write with same-cycle read.
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; set_rd(5, 0);
        expect_v(0, 0, 32'hDEADBEEF, "wr5_bypass_a");
        expect_v(3, 0, 32'h0, "wr5_nobypass_b");
        step();
        set_rd(5, 0);
        expect_ab(0, 0, 32'hDEADBEEF, "wr5_next");
        step();

        // Dual write collision, port 1 wins.
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22; set_rd(0, 7);
        expect_v(0, 1, 32'h22, "dual7_bypass_a");
        expect_v(3, 1, 32'h0, "dual7_nobypass_b");
        step();
        set_rd(0, 7);
        expect_ab(0, 1, 32'h22, "dual7_next");
        step();

        // Claim, then writeback clears busy.
        claim_en = 1; claim_addr = 3; set_rd(3, 0);
        expect_ab(1, 0, 32'h0, "claim3_same_cycle_busy");
        step();
        set_rd(3, 0);
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h5;
        expect_ab(2, 0, 32'h1, "claim3_cnt");
        expect_v(1, 0, 32'h0, "wr3_busy_a");
        expect_v(0, 0, 32'h5, "wr3_data_a");
        expect_v(4, 0, 32'h1, "wr3_busy_b");
        expect_v(3, 0, 32'h0, "wr3_data_b");
        step();
        set_rd(3, 0);
        expect_ab(2, 0, 32'h0, "wr3_cnt_after");
        expect_ab(1, 0, 32'h0, "wr3_busy_after");
        expect_ab(0, 0, 32'h5, "wr3_data_after");
        step();

        // Claims 4 and 6, then flush with claim 9.
        claim_en = 1; claim_addr = 4; step();
        claim_en = 1; claim_addr = 6; set_rd(4, 0);
        expect_ab(1, 0, 32'h1, "claim4_busy");
        expect_ab(2, 0, 32'h1, "claim4_cnt");
        step();
        flush = 1; claim_en = 1; claim_addr = 9; set_rd(4, 6);
        expect_ab(2, 0, 32'h2, "claim46_cnt");
        expect_ab(1, 0, 32'h1, "claim4_busy_pre_flush");
        expect_ab(1, 1, 32'h1, "claim6_busy_pre_flush");
        step();
        set_rd(9, 4);
        expect_ab(2, 0, 32'h1, "flush_cnt");
        expect_ab(1, 0, 32'h1, "flush_busy9");
        expect_ab(1, 1, 32'h0, "flush_busy4");
        step();
        set_rd(6, 3);
        expect_ab(1, 0, 32'h0, "flush_busy6");
        step();

        // Register 0 ignores writes and claims.
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF; claim_en = 1; claim_addr = 0; set_rd(0, 0);
        expect_ab(0, 0, 32'h0, "r0_data_same");
        expect_ab(1, 0, 32'h0, "r0_busy_same");
        step();
        set_rd(0, 0);
        expect_ab(0, 0, 32'h0, "r0_data_next");
        expect_ab(1, 1, 32'h0, "r0_busy_next");
        expect_ab(2, 0, 32'h1, "r0_cnt_unchanged");
        step();

        // Claim beats a same-cycle write; last index written through port 1.
        claim_en = 1; claim_addr = 10; wr1_en = 1; wr1_addr = 10; wr1_data = 32'hAB; step();
        wr1_en = 1; wr1_addr = 31; wr1_data = 32'hCAFEF00D; set_rd(10, 31);
        expect_ab(1, 0, 32'h1, "claim_over_wr_busy");
        expect_ab(0, 0, 32'hAB, "claim_over_wr_data");
        expect_ab(2, 0, 32'h2, "claim_over_wr_cnt");
        expect_v(0, 1, 32'hCAFEF00D, "wr31_bypass_a");
        expect_v(3, 1, 32'h0, "wr31_nobypass_b");
        step();
        set_rd(10, 31);
        expect_ab(0, 1, 32'hCAFEF00D, "wr31_next");
        step();

        // Reset overrides a same-cycle write and claim.
        rst = 1; wr0_en = 1; wr0_addr = 12; wr0_data = 32'h1234; claim_en = 1; claim_addr = 12;
        @(posedge clk); #1;
        rst = 0; idle(); set_rd(12, 31);
        expect_ab(0, 0, 32'h0, "rst2_data12");
        expect_ab(0, 1, 32'h0, "rst2_data31");
        expect_ab(1, 0, 32'h0, "rst2_busy12");
        expect_ab(2, 0, 32'h0, "rst2_cnt");
        step();
        step();

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
            $fatal(1, "timeout");
        end
    end

endmodule
